frame_tx_scheduler: RTL and testbench
=====================================

Name: frame_tx_scheduler

Overview:
- Decides which 128-bit frame the byte serializer sends next. Sources: periodic sync/stats frames, trace frames from the frame buffer, and host reply frames from the command path.
- Sits between the frame buffer, stats builder and command handler on one side, and the frame-to-serial stage on the other.
- Owns the sync interval timer, so the serializer just sends whatever frame it is handed.

Parameters:
- SYNC_INTERVAL, 24'h7FFFFF: cycles between sync frame requests; must be ≥1.
- SYNC_CNT_W, 24: width of the sync timer.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- TraceFrame  in  128  trace frame from frame buffer
- TraceReady  in  1  trace frame available
- TraceNext  out  1  one-cycle pulse: trace frame consumed
- ReplyFrame  in  128  host reply frame from command handler
- ReplyReady  in  1  reply frame available
- ReplyNext  out  1  one-cycle pulse: reply frame consumed
- SyncFrame  in  128  current sync/stats frame (combinational from stats builder)
- ForceSync  in  1  pulse: request a sync frame immediately
- OutFrame  out  128  frame for serializer
- OutValid  out  1  OutFrame holds an unsent frame
- OutAccept  in  1  serializer takes OutFrame this cycle
- OutSrc  out  2  source of OutFrame: 0 sync, 1 trace, 2 reply
- SyncDrops  out  8  saturating count of sync requests merged while one was already pending

Behaviour:
- Reset values: TraceNext=0, ReplyNext=0, OutValid=0, OutFrame=0, OutSrc=0, SyncDrops=0, syncPending=1 (first frame after reset is a sync), syncTimer=SYNC_INTERVAL-1, lastGrant=reply (trace wins first contention), state=ST_IDLE.
- Sync timer:
  - Decrements every cycle, including during reset release, and is independent of state.
  - At 0 it reloads SYNC_INTERVAL-1 and raises a sync request.
  - A sync request is either timer expiry or ForceSync.
  - A request sets syncPending.
  - A request arriving while syncPending is already 1 (and not cleared this cycle) increments SyncDrops; SyncDrops saturates at 8'hFF.
- ST_IDLE (OutValid=0): arbitrate in priority order.
  - syncPending is granted first: OutFrame<=SyncFrame, OutSrc<=0, syncPending<=0.
  - If both ReplyReady and TraceReady are set, round-robin: grant the source that is not lastGrant.
  - Otherwise grant the single ready source.
  - On a trace or reply grant: capture its frame into OutFrame, pulse its Next for exactly one cycle (same edge as the capture), and update lastGrant.
  - Any grant sets OutValid<=1 and moves to ST_HOLD.
  - With no requests, remain in ST_IDLE.
- Clear/set collision: a sync request in the same cycle syncPending is cleared by a grant sets syncPending again. It does not count as a drop.
- ST_HOLD (OutValid=1):
  - OutFrame and OutSrc are stable.
  - On OutAccept: OutValid<=0, return to ST_IDLE.
  - Minimum two cycles per frame; the one-cycle bubble is acceptable because the serializer needs 16 byte slots per frame.
- Latency: source Ready to OutValid is 1 cycle when the block is idle and the source wins.
- Next pulses are never issued unless the matching Ready was 1 in the granting cycle. Never more than one Next per cycle.
- OutAccept while OutValid=0 is ignored.
- Ready dropping while in ST_HOLD has no effect, because the frame is already captured.
- Reset asserted mid-operation: everything returns to reset values immediately. The held frame is discarded and no Next pulse is issued.

Decomposition:
- Shared package (frame_pkg):
  - FRAME_W=128
  - source encodings SRC_SYNC=0, SRC_TRACE=1, SRC_REPLY=2
  - sync header constants 8'hA6 and 32'hFFFFFF7F, used by the stats builder
- One natural sub-module: sync_timer. It holds the down-counter, reload and request pulse output, and is reused by future width/stats pacing.

Test Plan:
- Release reset with TraceReady=1 → the first OutValid carries OutSrc=0 (sync). The next frame is trace, with TraceNext pulsing once on its capture edge.
- SYNC_INTERVAL=32, no traffic, OutAccept tied 1 → OutValid with OutSrc=0 every 32 cycles; SyncDrops stays 0.
- TraceReady and ReplyReady both held 1, OutAccept=1 → OutSrc alternates 1,2,1,2. Each Next pulses once per grant and never both in one cycle.
- OutAccept held 0 for 100 cycles with SYNC_INTERVAL=32 → OutFrame is stable. SyncDrops=2 (the first expiry sets pending; the 2nd and 3rd are merged). After accept, a sync is granted.
- ForceSync in the same cycle a sync grant clears syncPending → a second sync frame follows; SyncDrops unchanged.
- rst asserted during ST_HOLD → OutValid=0 next edge. After release the first grant is sync and no TraceNext pulses for the dropped frame.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame widths, source encodings and sync header constants for the
// frame transmit path.
package frame_pkg;

   localparam int FRAME_W = 128;

   typedef enum logic [1:0] {
      SRC_SYNC  = 2'd0,
      SRC_TRACE = 2'd1,
      SRC_REPLY = 2'd2
   } src_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } sched_state_e;

   // Header fields the stats builder places at the front of every sync frame.
   localparam logic [7:0]  SYNC_HDR_BYTE = 8'hA6;
   localparam logic [31:0] SYNC_HDR_WORD = 32'hFFFFFF7F;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/frame_tx_scheduler_sync_timer.sv
// Free-running down-counter that emits a one-cycle request pulse every
// INTERVAL cycles; the pulse is registered.
module sync_timer #(
   parameter int              CNT_W    = 24,
   parameter logic [CNT_W-1:0] INTERVAL = 24'h7FFFFF
) (
   input  logic clk,
   input  logic rst,
   output logic req_o
);

   localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] RELOAD = INTERVAL - ONE;

   logic [CNT_W-1:0] cnt_q;
   logic             req_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= RELOAD;
         req_q <= 1'b0;
      end else if (cnt_q == {CNT_W{1'b0}}) begin
         cnt_q <= RELOAD;
         req_q <= 1'b1;
      end else begin
         cnt_q <= cnt_q - ONE;
         req_q <= 1'b0;
      end
   end

   assign req_o = req_q;

endmodule

// File: rtl/frame_tx_scheduler.sv
// Picks the next 128-bit frame for the serializer from sync, trace and reply
// sources, and holds it until the serializer accepts it.
module frame_tx_scheduler
   import frame_pkg::*;
#(
   parameter int                    SYNC_CNT_W    = 24,
   parameter logic [SYNC_CNT_W-1:0] SYNC_INTERVAL = 24'h7FFFFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FRAME_W-1:0] TraceFrame,
   input  logic               TraceReady,
   output logic               TraceNext,
   input  logic [FRAME_W-1:0] ReplyFrame,
   input  logic               ReplyReady,
   output logic               ReplyNext,
   input  logic [FRAME_W-1:0] SyncFrame,
   input  logic               ForceSync,
   output logic [FRAME_W-1:0] OutFrame,
   output logic               OutValid,
   input  logic               OutAccept,
   output logic [1:0]         OutSrc,
   output logic [7:0]         SyncDrops
);

   sched_state_e       state_q;
   logic [FRAME_W-1:0] out_frame_q;
   logic               out_valid_q;
   src_e               out_src_q;
   src_e               last_grant_q;
   logic               sync_pending_q;
   logic [7:0]         sync_drops_q;
   logic               trace_next_q;
   logic               reply_next_q;

   logic timer_req_s;
   logic sync_req_s;
   logic grant_sync_s;
   logic grant_trace_s;
   logic grant_reply_s;

   sync_timer #(
      .CNT_W    (SYNC_CNT_W),
      .INTERVAL (SYNC_INTERVAL)
   ) u_sync_timer (
      .clk   (clk),
      .rst   (rst),
      .req_o (timer_req_s)
   );

   // Pending sync beats both data sources; between the two, alternate on contention.
   always_comb begin
      sync_req_s    = timer_req_s | ForceSync;
      grant_sync_s  = 1'b0;
      grant_trace_s = 1'b0;
      grant_reply_s = 1'b0;
      if (state_q == ST_IDLE) begin
         if (sync_pending_q) begin
            grant_sync_s = 1'b1;
         end else if (TraceReady && ReplyReady) begin
            grant_trace_s = (last_grant_q == SRC_REPLY);
            grant_reply_s = (last_grant_q != SRC_REPLY);
         end else begin
            grant_trace_s = TraceReady;
            grant_reply_s = ReplyReady;
         end
      end else begin
         grant_sync_s = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         out_frame_q    <= {FRAME_W{1'b0}};
         out_valid_q    <= 1'b0;
         out_src_q      <= SRC_SYNC;
         last_grant_q   <= SRC_REPLY;
         sync_pending_q <= 1'b1;
         sync_drops_q   <= 8'h00;
         trace_next_q   <= 1'b0;
         reply_next_q   <= 1'b0;
      end else begin
         trace_next_q <= grant_trace_s;
         reply_next_q <= grant_reply_s;

         // A request landing on the clearing grant re-arms pending without counting a drop.
         if (sync_req_s) begin
            sync_pending_q <= 1'b1;
         end else if (grant_sync_s) begin
            sync_pending_q <= 1'b0;
         end else begin
            sync_pending_q <= sync_pending_q;
         end

         if (sync_req_s && sync_pending_q && !grant_sync_s) begin
            sync_drops_q <= sat_inc8(sync_drops_q);
         end else begin
            sync_drops_q <= sync_drops_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (grant_sync_s) begin
                  out_frame_q <= SyncFrame;
                  out_src_q   <= SRC_SYNC;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end else if (grant_trace_s) begin
                  out_frame_q  <= TraceFrame;
                  out_src_q    <= SRC_TRACE;
                  last_grant_q <= SRC_TRACE;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_HOLD;
               end else if (grant_reply_s) begin
                  out_frame_q  <= ReplyFrame;
                  out_src_q    <= SRC_REPLY;
                  last_grant_q <= SRC_REPLY;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_HOLD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (OutAccept) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign OutFrame  = out_frame_q;
   assign OutValid  = out_valid_q;
   assign OutSrc    = out_src_q;
   assign SyncDrops = sync_drops_q;
   assign TraceNext = trace_next_q;
   assign ReplyNext = reply_next_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed testbench for frame_tx_scheduler with a 32-cycle sync interval.
module tb_frame_tx_scheduler;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] TraceFrame = 128'd0;
   logic         TraceReady = 1'b0;
   logic         TraceNext;
   logic [127:0] ReplyFrame = 128'd0;
   logic         ReplyReady = 1'b0;
   logic         ReplyNext;
   logic [127:0] SyncFrame = 128'd0;
   logic         ForceSync = 1'b0;
   logic [127:0] OutFrame;
   logic         OutValid;
   logic         OutAccept = 1'b0;
   logic [1:0]   OutSrc;
   logic [7:0]   SyncDrops;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [127:0] SYNC_A = 128'hA6FFFFFF7F_0000_1111_2222_3333_44;
   localparam logic [127:0] SYNC_B = 128'hA6FFFFFF7F_5555_6666_7777_8888_99;
   localparam logic [127:0] TR_A   = 128'h7777_0000_DEAD_BEEF_0123_4567_89AB_CDEF;
   localparam logic [127:0] RP_A   = 128'h2222_1111_CAFE_F00D_FEDC_BA98_7654_3210;

   always #5 clk = ~clk;

   frame_tx_scheduler #(
      .SYNC_CNT_W    (24),
      .SYNC_INTERVAL (24'd32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .TraceFrame (TraceFrame),
      .TraceReady (TraceReady),
      .TraceNext  (TraceNext),
      .ReplyFrame (ReplyFrame),
      .ReplyReady (ReplyReady),
      .ReplyNext  (ReplyNext),
      .SyncFrame  (SyncFrame),
      .ForceSync  (ForceSync),
      .OutFrame   (OutFrame),
      .OutValid   (OutValid),
      .OutAccept  (OutAccept),
      .OutSrc     (OutSrc),
      .SyncDrops  (SyncDrops)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst        = 1'b1;
      TraceReady = 1'b0;
      ReplyReady = 1'b0;
      ForceSync  = 1'b0;
      OutAccept  = 1'b0;
      TraceFrame = TR_A;
      ReplyFrame = RP_A;
      SyncFrame  = SYNC_A;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
      tests_run++; if (OutFrame !== 128'd0) begin tests_failed++; $display("FAIL reset_outframe got %h want 0", OutFrame); end
      tests_run++; if (OutSrc !== 2'd0) begin tests_failed++; $display("FAIL reset_outsrc got %0d want 0", OutSrc); end
      tests_run++; if (SyncDrops !== 8'd0) begin tests_failed++; $display("FAIL reset_drops got %0d want 0", SyncDrops); end
      tests_run++; if ({TraceNext, ReplyNext} !== 2'b00) begin tests_failed++; $display("FAIL reset_next got %b want 00", {TraceNext, ReplyNext}); end
      apply_reset();
      TraceReady = 1'b1;
      OutAccept  = 1'b1;
      tick();
      tests_run++; if ({OutValid, OutSrc, TraceNext} !== {1'b1, 2'd0, 1'b0}) begin tests_failed++; $display("FAIL first_is_sync got v=%b src=%0d tn=%b want v=1 src=0 tn=0", OutValid, OutSrc, TraceNext); end
      tests_run++; if (OutFrame !== SYNC_A) begin tests_failed++; $display("FAIL first_sync_frame got %h want %h", OutFrame, SYNC_A); end
      tick();
      tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL bubble_after_accept got %b want 0", OutValid); end
      tick();
      tests_run++; if ({OutValid, OutSrc, TraceNext, ReplyNext} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL trace_grant got v=%b src=%0d tn=%b rn=%b want v=1 src=1 tn=1 rn=0", OutValid, OutSrc, TraceNext, ReplyNext); end
      tests_run++; if (OutFrame !== TR_A) begin tests_failed++; $display("FAIL trace_frame got %h want %h", OutFrame, TR_A); end
      TraceReady = 1'b0;
      tick();
      tests_run++; if ({TraceNext, OutValid} !== 2'b00) begin tests_failed++; $display("FAIL trace_next_single got tn=%b v=%b want 0 0", TraceNext, OutValid); end
   endtask

   task automatic test_periodic_sync();
      int times[5];
      int exp_times[5] = '{1, 34, 66, 98, 130};
      int n = 0;
      int bad_src = 0;
      apply_reset();
      OutAccept = 1'b1;
      for (int i = 1; i <= 140; i++) begin
         tick();
         if (OutValid) begin
            if (n < 5) times[n] = i;
            if (OutSrc !== 2'd0) bad_src++;
            n++;
         end
      end
      tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL periodic_count got %0d want 5", n); end
      for (int k = 0; k < 5; k++) begin
         if (k < n) begin
            tests_run++; if (times[k] !== exp_times[k]) begin tests_failed++; $display("FAIL periodic_time[%0d] got %0d want %0d", k, times[k], exp_times[k]); end
         end
      end
      tests_run++; if (bad_src !== 0) begin tests_failed++; $display("FAIL periodic_src got %0d non-sync frames want 0", bad_src); end
      tests_run++; if (SyncDrops !== 8'd0) begin tests_failed++; $display("FAIL periodic_drops got %0d want 0", SyncDrops); end
   endtask

   task automatic test_round_robin();
      logic [1:0] srcs[4];
      logic [1:0] exp_srcs[4] = '{2'd1, 2'd2, 2'd1, 2'd2};
      int n = 0, tn = 0, rn = 0, both = 0, bad_pair = 0;
      apply_reset();
      TraceReady = 1'b1;
      ReplyReady = 1'b1;
      OutAccept  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (TraceNext && ReplyNext) both++;
         if (TraceNext) tn++;
         if (ReplyNext) rn++;
         if (OutValid && OutSrc != 2'd0) begin
            if (n < 4) srcs[n] = OutSrc;
            n++;
            if (OutSrc == 2'd1 && (!TraceNext || OutFrame !== TR_A)) bad_pair++;
            if (OutSrc == 2'd2 && (!ReplyNext || OutFrame !== RP_A)) bad_pair++;
         end
      end
      TraceReady = 1'b0;
      ReplyReady = 1'b0;
      tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL rr_grants got %0d want 4", n); end
      for (int k = 0; k < 4; k++) begin
         if (k < n) begin
            tests_run++; if (srcs[k] !== exp_srcs[k]) begin tests_failed++; $display("FAIL rr_src[%0d] got %0d want %0d", k, srcs[k], exp_srcs[k]); end
         end
      end
      tests_run++; if ({tn, rn} !== {32'd2, 32'd2}) begin tests_failed++; $display("FAIL rr_next_counts got tn=%0d rn=%0d want 2 2", tn, rn); end
      tests_run++; if (both !== 0) begin tests_failed++; $display("FAIL rr_both_next got %0d want 0", both); end
      tests_run++; if (bad_pair !== 0) begin tests_failed++; $display("FAIL rr_frame_next_pair got %0d bad want 0", bad_pair); end
   endtask

   task automatic test_hold_stall();
      int unstable = 0;
      apply_reset();
      tick();
      tests_run++; if ({OutValid, OutSrc} !== {1'b1, 2'd0}) begin tests_failed++; $display("FAIL stall_first got v=%b src=%0d want 1 0", OutValid, OutSrc); end
      SyncFrame = SYNC_B;
      for (int i = 2; i <= 110; i++) begin
         tick();
         if (OutFrame !== SYNC_A || OutValid !== 1'b1) unstable++;
      end
      tests_run++; if (unstable !== 0) begin tests_failed++; $display("FAIL stall_stable got %0d changed cycles want 0", unstable); end
      tests_run++; if (SyncDrops !== 8'd2) begin tests_failed++; $display("FAIL stall_drops got %0d want 2", SyncDrops); end
      OutAccept = 1'b1;
      tick();
      tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL stall_accept got %b want 0", OutValid); end
      OutAccept = 1'b0;
      tick();
      tests_run++; if ({OutValid, OutSrc} !== {1'b1, 2'd0}) begin tests_failed++; $display("FAIL stall_next_sync got v=%b src=%0d want 1 0", OutValid, OutSrc); end
      tests_run++; if (OutFrame !== SYNC_B) begin tests_failed++; $display("FAIL stall_next_frame got %h want %h", OutFrame, SYNC_B); end
      tests_run++; if (SyncDrops !== 8'd2) begin tests_failed++; $display("FAIL stall_drops_after got %0d want 2", SyncDrops); end
   endtask

   task automatic test_force_collision();
      apply_reset();
      ForceSync = 1'b1;
      tick();
      tests_run++; if ({OutValid, OutSrc, SyncDrops} !== {1'b1, 2'd0, 8'd0}) begin tests_failed++; $display("FAIL collide_grant got v=%b src=%0d drops=%0d want 1 0 0", OutValid, OutSrc, SyncDrops); end
      ForceSync = 1'b0;
      OutAccept = 1'b1;
      tick();
      SyncFrame = SYNC_B;
      OutAccept = 1'b0;
      tick();
      tests_run++; if ({OutValid, OutSrc} !== {1'b1, 2'd0}) begin tests_failed++; $display("FAIL collide_second_sync got v=%b src=%0d want 1 0", OutValid, OutSrc); end
      tests_run++; if (OutFrame !== SYNC_B) begin tests_failed++; $display("FAIL collide_second_frame got %h want %h", OutFrame, SYNC_B); end
      tests_run++; if (SyncDrops !== 8'd0) begin tests_failed++; $display("FAIL collide_drops got %0d want 0", SyncDrops); end
      ForceSync = 1'b1;
      tick();
      tick();
      ForceSync = 1'b0;
      tests_run++; if (SyncDrops !== 8'd1) begin tests_failed++; $display("FAIL force_merge_drops got %0d want 1", SyncDrops); end
   endtask

   task automatic test_reset_in_hold();
      int tn = 0;
      apply_reset();
      TraceReady = 1'b1;
      OutAccept  = 1'b1;
      tick();
      tick();
      tick();
      tests_run++; if ({OutValid, OutSrc, TraceNext} !== {1'b1, 2'd1, 1'b1}) begin tests_failed++; $display("FAIL rsthold_trace got v=%b src=%0d tn=%b want 1 1 1", OutValid, OutSrc, TraceNext); end
      OutAccept  = 1'b0;
      TraceReady = 1'b0;
      tick();
      tests_run++; if ({OutValid, OutFrame} !== {1'b1, TR_A}) begin tests_failed++; $display("FAIL ready_drop_hold got v=%b frame=%h want 1 %h", OutValid, OutFrame, TR_A); end
      TraceReady = 1'b1;
      rst = 1'b1;
      #1;
      tests_run++; if ({OutValid, OutFrame} !== {1'b0, 128'd0}) begin tests_failed++; $display("FAIL rsthold_async got v=%b frame=%h want 0 0", OutValid, OutFrame); end
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (TraceNext) tn++;
         if (i == 1) begin
            tests_run++; if ({OutValid, OutSrc} !== {1'b1, 2'd0}) begin tests_failed++; $display("FAIL rsthold_first_sync got v=%b src=%0d want 1 0", OutValid, OutSrc); end
         end
      end
      tests_run++; if (tn !== 0) begin tests_failed++; $display("FAIL rsthold_no_next got %0d pulses want 0", tn); end
      TraceReady = 1'b0;
   endtask

   initial begin
      test_reset();
      test_periodic_sync();
      test_round_robin();
      test_hold_stall();
      test_force_collision();
      test_reset_in_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
